// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//   lsu_state_e : FSM state encoding (IDLE, LOAD, READ, WRITE, RESP)
//   F3_*        : funct3 access-size/extension codes
//   lsu_misaligned : alignment rule for a funct3 at a given byte offset
// Optional feature macro: LSU_SUBWORD_EN (byte/half accesses).
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] byte_off);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = byte_off[0];
            F3_W:        mis = (byte_off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Request/response channel between the execute stage and the load/store unit.
//   master : execute stage (drives req_*, observes req_ready and resp_*)
//   slave  : load/store unit
// ---------------------------------------------------------------------------
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_lane.sv
// ---------------------------------------------------------------------------
// lsu_lane (combinational)
// Lane handling for the load/store unit.
//   funct3     in  3   access size / extension
//   byte_off   in  2   byte offset inside the word
//   rd_word    in  32  word read from data memory
//   wdata      in  32  right-justified store data
//   load_data  out 32  selected lane, sign/zero extended
//   merge_data out 32  rd_word with the store lane replaced (wdata for words)
// Optional feature macro: LSU_SUBWORD_EN. Without it only whole words pass.
// ---------------------------------------------------------------------------
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

`ifdef LSU_SUBWORD_EN
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction/extension for loads and lane replacement for stores.
    always_comb begin
        byte_s     = rd_word[{byte_off, 3'b000} +: 8];
        half_s     = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        load_data  = 32'h0000_0000;
        merge_data = rd_word;
        case (funct3)
            F3_W: begin
                load_data  = rd_word;
                merge_data = wdata;
            end
            F3_B: begin
                load_data = {{24{byte_s[7]}}, byte_s};
                merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                load_data = {{16{half_s[15]}}, half_s};
                if (byte_off[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0] = wdata[15:0];
                end
            end
            F3_BU: begin
                load_data = {24'h00_0000, byte_s};
            end
            F3_HU: begin
                load_data = {16'h0000, half_s};
            end
            default: begin
                load_data  = 32'h0000_0000;
                merge_data = rd_word;
            end
        endcase
    end
`else
    logic unused_off_s;
    assign unused_off_s = ^byte_off;

    // Word-only build: pass the whole word through in both directions.
    always_comb begin
        load_data  = 32'h0000_0000;
        merge_data = rd_word;
        case (funct3)
            F3_W: begin
                load_data  = rd_word;
                merge_data = wdata;
            end
            default: begin
                load_data  = 32'h0000_0000;
                merge_data = rd_word;
            end
        endcase
    end
`endif

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Core-side initiator for a word-addressed data memory (async read, posedge
// write). Takes one request at a time, checks it, turns it into aligned word
// accesses (read-modify-write for sub-word stores) and returns one response.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   bus (slave)    req_valid/ready/we/funct3/addr/wdata, resp_valid/rdata/err
//   mem_WE         data memory write enable (only in WRITE)
//   mem_A          word-aligned byte address, always {addr_q[31:2],2'b00}
//   mem_WD         data memory write data
//   mem_RD         data memory read data
// Parameter MEM_WORDS: number of implemented words; larger word index faults.
// Optional feature macro: LSU_SUBWORD_EN (byte/half loads and stores).
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST,
    lsu_if.slave        bus,
    output logic        mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    lsu_state_e  state_r;
    logic        req_ready_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;
    logic        mem_we_r;
    logic [31:0] mem_wd_r;
    logic [31:0] addr_r;
    logic [2:0]  funct3_r;
    logic [31:0] wdata_r;

    logic        legal_s;
    logic        out_of_range_s;
    logic        req_err_s;
    logic [31:0] load_s;
    logic [31:0] merge_s;

    // Request legality: funct3 for the direction, alignment and word range.
    always_comb begin
        legal_s = 1'b0;
`ifdef LSU_SUBWORD_EN
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: legal_s = 1'b1;
            F3_BU, F3_HU:     legal_s = ~bus.req_we;
            default:          legal_s = 1'b0;
        endcase
`else
        legal_s = (bus.req_funct3 == F3_W);
`endif
        out_of_range_s = ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
        req_err_s = ~legal_s | out_of_range_s
                  | lsu_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    end

    lsu_lane u_lane (
        .funct3     (funct3_r),
        .byte_off   (addr_r[1:0]),
        .rd_word    (mem_RD),
        .wdata      (wdata_r),
        .load_data  (load_s),
        .merge_data (merge_s)
    );

`ifndef LSU_SUBWORD_EN
    logic unused_merge_s;
    assign unused_merge_s = ^merge_s;
`endif

    // Transaction FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_wd_r     <= 32'h0000_0000;
            addr_r       <= 32'h0000_0000;
            funct3_r     <= 3'b000;
            wdata_r      <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        addr_r      <= bus.req_addr;
                        funct3_r    <= bus.req_funct3;
                        wdata_r     <= bus.req_wdata;
                        req_ready_r <= 1'b0;
                        if (req_err_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                        end else if (!bus.req_we) begin
                            state_r <= LOAD;
                        end else if (bus.req_funct3 == F3_W) begin
                            // Full word store needs no read of the old contents.
                            state_r  <= WRITE;
                            mem_we_r <= 1'b1;
                            mem_wd_r <= bus.req_wdata;
                        end else begin
`ifdef LSU_SUBWORD_EN
                            state_r <= READ;
`else
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
`endif
                        end
                    end
                end
                LOAD: begin
                    state_r      <= RESP;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= load_s;
                end
`ifdef LSU_SUBWORD_EN
                READ: begin
                    // mem_A already points at the target word; merge the lane now.
                    state_r  <= WRITE;
                    mem_we_r <= 1'b1;
                    mem_wd_r <= merge_s;
                end
`endif
                WRITE: begin
                    state_r      <= RESP;
                    mem_we_r     <= 1'b0;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                end
                RESP: begin
                    state_r      <= IDLE;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    req_ready_r  <= 1'b1;
                end
                default: begin
                    state_r      <= IDLE;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    mem_we_r     <= 1'b0;
                    req_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign mem_WE         = mem_we_r;
    assign mem_A          = {addr_r[31:2], 2'b00};
    assign mem_WD         = mem_wd_r;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Drives load/store requests into load_store_unit against a behavioural data
// memory and a byte-level reference model of memory contents, responses,
// latency and write activity. Honours LSU_SUBWORD_EN.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int MEM_WORDS = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    logic [31:0] dmem    [0:127];
    logic [31:0] ref_mem [0:127];

    int checks   = 0;
    int failures = 0;

    lsu_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .bus    (bus),
        .mem_WE (mem_WE),
        .mem_A  (mem_A),
        .mem_WD (mem_WD),
        .mem_RD (mem_RD)
    );

    always #5 CLK = ~CLK;

    // Data memory: combinational read, posedge write.
    assign mem_RD = dmem[mem_A[8:2]];
    always @(posedge CLK) begin
        if (mem_WE === 1'b1) dmem[mem_A[8:2]] <= mem_WD;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
`ifdef LSU_SUBWORD_EN
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
`else
        legal = (f3 == 3'd2);
`endif
        return !legal || ((addr % size_of(f3)) != 0) || ((addr >> 2) >= MEM_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [63:0] v;
        logic [63:0] span;
        int sz;
        sz   = size_of(f3);
        span = 64'd1 << (8 * sz);
        v    = ({32'd0, ref_mem[addr[8:2]]} >> (8 * addr[1:0])) % span;
        if (f3[2] == 1'b0 && sz < 4 && v >= (span >> 1)) v = v - span;
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] w;
        int off;
        w   = ref_mem[addr[8:2]];
        off = int'(addr[1:0]);
        for (int b = 0; b < size_of(f3); b++) w[8 * (off + b) +: 8] = wdata[8 * b +: 8];
        ref_mem[addr[8:2]] = w;
    endtask

    // ---------------- driver + checker for one request ----------------
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
        int          wait_cyc;
        int          lat;
        int          we_cnt;
        logic        got;
        logic        err;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;

        wait_cyc = 0;
        while (bus.req_ready !== 1'b1 && wait_cyc < 20) begin
            @(negedge CLK);
            wait_cyc++;
        end
        check_value("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge CLK);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_funct3 = 3'($urandom);
        bus.req_we     = 1'($urandom);

        got = 1'b0; lat = 0; we_cnt = 0; err = 1'b0; rdata = 32'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (c == 1) check_value("mem_A", mem_A, {addr[31:2], 2'b00});
            if (mem_WE === 1'b1) we_cnt++;
            if (bus.resp_valid === 1'b1) begin
                got   = 1'b1;
                lat   = c;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
            check_value("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
        end

        exp_err = model_err(we, f3, addr);
        exp_rd  = 32'd0;
        if (exp_err) exp_lat = 1;
        else if (!we) exp_lat = 2;
        else if (size_of(f3) == 4) exp_lat = 3 - 1;
        else exp_lat = 3;
        if (!exp_err && !we) exp_rd = model_load(f3, addr);
        if (!exp_err && we) model_store(f3, addr, wdata);

        check_value("resp_seen", {31'd0, got}, 32'd1);
        check_value("latency", 32'(lat), 32'(exp_lat));
        check_value("resp_err", {31'd0, err}, {31'd0, exp_err});
        check_value("resp_rdata", rdata, exp_rd);
        check_value("write_pulses", 32'(we_cnt), (!exp_err && we) ? 32'd1 : 32'd0);

        @(negedge CLK);
        check_value("resp_one_cycle", {31'd0, bus.resp_valid}, 32'd0);
        check_value("ready_after", {31'd0, bus.req_ready}, 32'd1);
        check_value("mem_word", dmem[addr[8:2]], ref_mem[addr[8:2]]);
    endtask

    logic [31:0] r;
    int          pulses;
    int          resps;
    logic [2:0]  rf3;
    logic [31:0] raddr;

    initial begin
        for (int i = 0; i < 128; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr  = 32'd0; bus.req_wdata = 32'd0;

        // Reset state.
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_value("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_value("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_value("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check_value("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check_value("rst_mem_WE", {31'd0, mem_WE}, 32'd0);
        check_value("rst_mem_A", mem_A, 32'd0);
        check_value("rst_mem_WD", mem_WD, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Reset in the middle of a transaction aborts it.
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0021; bus.req_wdata = 32'h0000_0055;
`ifdef LSU_SUBWORD_EN
        bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
`else
        bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0000_0020;
`endif
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        pulses = 0; resps = 0;
        @(negedge CLK);
        if (mem_WE === 1'b1) pulses++;
        RST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            if (mem_WE === 1'b1) pulses++;
            if (bus.resp_valid === 1'b1) resps++;
        end
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (mem_WE === 1'b1) pulses++;
            if (bus.resp_valid === 1'b1) resps++;
        end
        check_value("abort_no_write", 32'(pulses), 32'd0);
        check_value("abort_no_resp", 32'(resps), 32'd0);
        check_value("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        check_value("abort_mem", dmem[8], ref_mem[8]);

        // Directed cases.
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, r);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, r);
        check_value("lw_deadbeef", r, 32'hDEAD_BEEF);
        do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, r);
`ifdef LSU_SUBWORD_EN
        do_req(1'b1, 3'b000, 32'h11, 32'h0000_00AA, r);
        check_value("sb_word", dmem[4], 32'h1122_AA44);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, r);
        check_value("lb_aa", r, 32'hFFFF_FFAA);
        do_req(1'b0, 3'b100, 32'h11, 32'h0, r);
        check_value("lbu_aa", r, 32'h0000_00AA);
        do_req(1'b1, 3'b001, 32'h12, 32'h0000_8001, r);
        check_value("sh_word", dmem[4], 32'h8001_AA44);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, r);
        check_value("lh_8001", r, 32'hFFFF_8001);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, r);
        check_value("lhu_8001", r, 32'h0000_8001);
`else
        do_req(1'b0, 3'b000, 32'h0, 32'h0, r);
`endif
        do_req(1'b0, 3'b010, 32'h102, 32'h0, r);
        do_req(1'b0, 3'b001, 32'h13, 32'h0, r);
        do_req(1'b1, 3'b010, 32'h100, 32'h1234_5678, r);
        do_req(1'b0, 3'b010, 32'hFC, 32'h0, r);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            rf3   = 3'($urandom_range(0, 7));
            raddr = {23'd0, 7'($urandom_range(0, 70)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) raddr = raddr | 32'h8000_0000;
            do_req(1'($urandom), rf3, raddr, $urandom, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
